// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-bank port scheduler.
// Read-FSM state encoding, bank geometry and small helpers live here.
package regfile_pkg;

    localparam int REGISTER_SIZE       = 32;
    localparam int AMOUNT_OF_REGISTERS = 16;
    localparam int REG_ADDR_W          = $clog2(AMOUNT_OF_REGISTERS);

    typedef logic [REGISTER_SIZE-1:0] word_t;
    typedef logic [REG_ADDR_W-1:0]    reg_addr_t;

    localparam reg_addr_t PC_REG = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_A = 3'd1,
        ADDR_B = 3'd2,
        CAP_B  = 3'd3,
        OUT    = 3'd4
    } rd_state_e;

    // A write committing to the register being addressed this cycle must be
    // forwarded, because the bank hands back the pre-write value.
    function automatic logic bypass_hit(input logic wen, input reg_addr_t wreg,
                                        input reg_addr_t rreg);
        return wen && (wreg == rreg);
    endfunction

endpackage

// File: rtl/regfile_port_scheduler_if.sv
// Signal bundle between the port scheduler and decode, writeback and the bank.
// slave = the scheduler itself; master = everything around it.
interface regfile_port_scheduler_if;
    import regfile_pkg::*;

    // Every valid/ready pair: a transfer happens on a rising clk edge where
    // both are high; the source keeps valid and payload stable until then,
    // and ready may depend combinationally on valid.
    logic      rd_req_valid;
    logic      rd_req_ready;
    reg_addr_t rd_req_rn;
    reg_addr_t rd_req_rm;
    logic      rd_req_two;

    logic      op_valid;
    logic      op_ready;
    word_t     op_a;
    word_t     op_b;

    logic      wb_alu_valid;
    logic      wb_alu_ready;
    reg_addr_t wb_alu_reg;
    word_t     wb_alu_data;

    logic      wb_mem_valid;
    logic      wb_mem_ready;
    reg_addr_t wb_mem_reg;
    word_t     wb_mem_data;

    logic      rf_write_en;
    reg_addr_t rf_write_reg;
    word_t     rf_write_value;
    reg_addr_t rf_read_reg;
    word_t     rf_read_value;

    // Debug visibility: read-FSM state and writes landing on the PC.
    rd_state_e dbg_state;
    logic      dbg_pc_write;

    modport slave (
        input  rd_req_valid, rd_req_rn, rd_req_rm, rd_req_two,
        output rd_req_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  wb_alu_valid, wb_alu_reg, wb_alu_data,
        output wb_alu_ready,
        input  wb_mem_valid, wb_mem_reg, wb_mem_data,
        output wb_mem_ready,
        output rf_write_en, rf_write_reg, rf_write_value, rf_read_reg,
        input  rf_read_value,
        output dbg_state, dbg_pc_write
    );

    modport master (
        output rd_req_valid, rd_req_rn, rd_req_rm, rd_req_two,
        input  rd_req_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output wb_alu_valid, wb_alu_reg, wb_alu_data,
        input  wb_alu_ready,
        output wb_mem_valid, wb_mem_reg, wb_mem_data,
        input  wb_mem_ready,
        input  rf_write_en, rf_write_reg, rf_write_value, rf_read_reg,
        output rf_read_value,
        input  dbg_state, dbg_pc_write
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter (ALU vs MEM) for the single bank write port.
// Grants are combinational; the 1-bit pointer only moves when both compete.
module wb_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    logic ptr_mem;  // 1: MEM wins the next contention, 0: ALU wins

    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (!reset) begin
            if (req_alu && req_mem) begin
                gnt_alu = !ptr_mem;
                gnt_mem = ptr_mem;
            end else begin
                gnt_alu = req_alu;
                gnt_mem = req_mem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_mem <= 1'b0;
        end else if (req_alu && req_mem) begin
            ptr_mem <= !ptr_mem;
        end
    end

endmodule

// File: rtl/regfile_port_scheduler.sv
// Serialises operand fetches over the bank's single registered read port and
// arbitrates ALU/MEM writeback onto its write port, forwarding same-cycle writes.
module regfile_port_scheduler
    import regfile_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    regfile_port_scheduler_if.slave  bus
);

    rd_state_e state, state_nxt;
    reg_addr_t rn_q, rm_q;
    logic      two_q;
    word_t     op_a_q, op_b_q;
    logic      byp_a_q, byp_b_q;
    word_t     byp_a_data_q, byp_b_data_q;

    logic      rd_ready;
    logic      accept;
    reg_addr_t read_reg;
    logic      byp_now;

    logic      gnt_alu, gnt_mem;
    logic      wr_en;
    reg_addr_t wr_reg;
    word_t     wr_value;

    // ---------------- write port ----------------
    wb_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_alu (bus.wb_alu_valid),
        .req_mem (bus.wb_mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    always_comb begin
        wr_en    = gnt_alu || gnt_mem;
        wr_reg   = '0;
        wr_value = '0;
        if (gnt_alu) begin
            wr_reg   = bus.wb_alu_reg;
            wr_value = bus.wb_alu_data;
        end else if (gnt_mem) begin
            wr_reg   = bus.wb_mem_reg;
            wr_value = bus.wb_mem_data;
        end
    end

    assign bus.wb_alu_ready   = gnt_alu;
    assign bus.wb_mem_ready   = gnt_mem;
    assign bus.rf_write_en    = wr_en;
    assign bus.rf_write_reg   = wr_reg;
    assign bus.rf_write_value = wr_value;
    assign bus.dbg_pc_write   = wr_en && (wr_reg == PC_REG);

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_ready  = 1'b0;
        read_reg  = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    rd_ready = 1'b1;
                    if (bus.rd_req_valid) state_nxt = ADDR_A;
                end
                ADDR_A: begin
                    read_reg  = rn_q;
                    state_nxt = ADDR_B;
                end
                ADDR_B: begin
                    if (two_q) begin
                        read_reg  = rm_q;
                        state_nxt = CAP_B;
                    end else begin
                        state_nxt = OUT;
                    end
                end
                CAP_B: state_nxt = OUT;
                OUT: begin
                    if (bus.op_ready) begin
                        rd_ready  = 1'b1;
                        state_nxt = bus.rd_req_valid ? ADDR_A : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign accept  = rd_ready && bus.rd_req_valid;
    assign byp_now = bypass_hit(wr_en, wr_reg, read_reg);

    // Operand snapshots only move at their capture cycle, so they stay stable in OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            rn_q         <= '0;
            rm_q         <= '0;
            two_q        <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            byp_a_q      <= 1'b0;
            byp_b_q      <= 1'b0;
            byp_a_data_q <= '0;
            byp_b_data_q <= '0;
        end else begin
            if (accept) begin
                rn_q    <= bus.rd_req_rn;
                rm_q    <= bus.rd_req_rm;
                two_q   <= bus.rd_req_two;
                byp_a_q <= 1'b0;
                byp_b_q <= 1'b0;
            end
            case (state)
                ADDR_A: begin
                    byp_a_q      <= byp_now;
                    byp_a_data_q <= wr_value;
                end
                ADDR_B: begin
                    op_a_q <= byp_a_q ? byp_a_data_q : bus.rf_read_value;
                    if (two_q) begin
                        byp_b_q      <= byp_now;
                        byp_b_data_q <= wr_value;
                    end else begin
                        op_b_q <= '0;
                    end
                end
                CAP_B: op_b_q <= byp_b_q ? byp_b_data_q : bus.rf_read_value;
                default: ;
            endcase
        end
    end

    assign bus.rd_req_ready = rd_ready;
    assign bus.op_valid     = !reset && (state == OUT);
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.rf_read_reg  = read_reg;
    assign bus.dbg_state    = state;

endmodule
